// File: rtl/fpdlink_pkg.sv
// Shared lane-group layout for the FPD-Link dual-pixel word (TX and RX).
package fpdlink_pkg;

    localparam int GROUP_W    = 21;
    localparam int WORD_W     = 2 * GROUP_W;
    localparam int PIX_W      = 18;
    localparam int PIX_PAIR_W = 2 * PIX_W;

    // Bit positions within one 21-bit lane group
    localparam int B_HI_LSB = 0;    // b[5:2]
    localparam int HS_POS   = 4;
    localparam int VS_POS   = 5;
    localparam int DE_POS   = 6;
    localparam int G_HI_LSB = 7;    // g[5:1]
    localparam int B_LO_LSB = 12;   // b[1:0]
    localparam int R_LSB    = 14;   // r[5:0]
    localparam int G_LO_POS = 20;   // g[0]

    // Packs one pixel {r, g, b} (6 bits each) plus timing into a lane group.
    function automatic logic [GROUP_W-1:0] pack_group(
        input logic [PIX_W-1:0] pix,
        input logic             hsync,
        input logic             vsync,
        input logic             de
    );
        logic [GROUP_W-1:0] grp;
        grp                   = '0;
        grp[R_LSB +: 6]       = pix[17:12];
        grp[G_HI_LSB +: 5]    = pix[11:7];
        grp[G_LO_POS]         = pix[6];
        grp[B_HI_LSB +: 4]    = pix[5:2];
        grp[B_LO_LSB +: 2]    = pix[1:0];
        grp[HS_POS]           = hsync;
        grp[VS_POS]           = vsync;
        grp[DE_POS]           = de;
        return grp;
    endfunction

endpackage

// File: rtl/fpdlink_timing_gen.sv
// Panel timing counters with active/sync/origin decode.
module fpdlink_timing_gen #(
    parameter int H_ACTIVE = 400,
    parameter int H_FP     = 20,
    parameter int H_SYNC   = 10,
    parameter int H_BP     = 30,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_de,
    output logic o_hs_act,
    output logic o_vs_act,
    output logic o_origin
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCNT_W  = $clog2(H_TOTAL);
    localparam int VCNT_W  = $clog2(V_TOTAL);

    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic              w_h_last;
    logic              w_v_last;

    assign w_h_last = (int'(r_hcnt) == H_TOTAL - 1);
    assign w_v_last = (int'(r_vcnt) == V_TOTAL - 1);

    // Raster scan; held at the origin while disabled so enable always starts a fresh frame
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    assign o_de     = (int'(r_hcnt) < H_ACTIVE) && (int'(r_vcnt) < V_ACTIVE);
    assign o_hs_act = (int'(r_hcnt) >= H_ACTIVE + H_FP) &&
                      (int'(r_hcnt) <  H_ACTIVE + H_FP + H_SYNC);
    assign o_vs_act = (int'(r_vcnt) >= V_ACTIVE + V_FP) &&
                      (int'(r_vcnt) <  V_ACTIVE + V_FP + V_SYNC);
    assign o_origin = (r_hcnt == '0) && (r_vcnt == '0);

endmodule

// File: rtl/fpdlink_tx_framer.sv
// FPD-Link dual-pixel transmit framer: timing generation, pixel pull and word packing.
module fpdlink_tx_framer
    import fpdlink_pkg::*;
#(
    parameter int   H_ACTIVE = 400,
    parameter int   H_FP     = 20,
    parameter int   H_SYNC   = 10,
    parameter int   H_BP     = 30,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr_err,
    input  logic [PIX_PAIR_W-1:0] s_pixel,
    input  logic                  s_sof,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [WORD_W-1:0]     dout,
    output logic                  frame_start,
    output logic                  underflow,
    output logic                  sof_err
);

    logic                  w_de;
    logic                  w_hs_act;
    logic                  w_vs_act;
    logic                  w_origin;
    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_hsync;
    logic                  w_vsync;
    logic                  w_uf_set;
    logic                  w_sof_set;
    logic [PIX_PAIR_W-1:0] w_pix;
    logic [WORD_W-1:0]     w_word;
    logic [WORD_W-1:0]     w_idle;

    logic [WORD_W-1:0]     r_dout;
    logic                  r_frame_start;
    logic                  r_underflow;
    logic                  r_sof_err;

    fpdlink_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (en),
        .o_de     (w_de),
        .o_hs_act (w_hs_act),
        .o_vs_act (w_vs_act),
        .o_origin (w_origin)
    );

    // Nothing is accepted during reset: the counters are not advancing then.
    assign w_ready = en && w_de && !rst;
    assign w_xfer  = w_ready && s_valid;
    assign w_hsync = w_hs_act ? HS_POL : ~HS_POL;
    assign w_vsync = w_vs_act ? VS_POL : ~VS_POL;

    // Missing pixel in the active area goes out as black; timing keeps running
    assign w_pix  = w_xfer ? s_pixel : '0;
    assign w_word = {pack_group(w_pix[PIX_PAIR_W-1:PIX_W], w_hsync, w_vsync, w_de),
                     pack_group(w_pix[PIX_W-1:0],          w_hsync, w_vsync, w_de)};
    assign w_idle = {pack_group('0, ~HS_POL, ~VS_POL, 1'b0),
                     pack_group('0, ~HS_POL, ~VS_POL, 1'b0)};

    assign w_uf_set  = en && w_de && !s_valid;
    assign w_sof_set = w_xfer && (s_sof != w_origin);

    // Output word register and sticky flags; a set in the same cycle as clr_err wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout        <= w_idle;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
            r_sof_err     <= 1'b0;
        end else begin
            if (en) begin
                r_dout        <= w_word;
                r_frame_start <= w_origin;
            end else begin
                r_dout        <= w_idle;
                r_frame_start <= 1'b0;
            end
            r_underflow <= (r_underflow && !clr_err) || w_uf_set;
            r_sof_err   <= (r_sof_err   && !clr_err) || w_sof_set;
        end
    end

    assign s_ready     = w_ready;
    assign dout        = r_dout;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;
    assign sof_err     = r_sof_err;

endmodule

// File: tb/tb_fpdlink_tx_framer.sv
// Self-checking bench for fpdlink_tx_framer: directed scenarios plus random traffic
// against a frame-position reference model. Two instances cover both sync polarities.
module tb_fpdlink_tx_framer;

    localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;   // 14
    localparam int VT = VA + VFP + VSW + VBP;   // 7
    localparam int FRAME = HT * VT;             // 98

    logic        clk = 1'b0;
    logic        rst, en, clr_err, s_sof, s_valid;
    logic [35:0] s_pixel;
    logic        rdy_p, rdy_n, fs_p, fs_n, uf_p, uf_n, se_p, se_n;
    logic [41:0] dout_p, dout_n;

    always #5 clk = ~clk;

    fpdlink_tx_framer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_p (
        .clk(clk), .rst(rst), .en(en), .clr_err(clr_err),
        .s_pixel(s_pixel), .s_sof(s_sof), .s_valid(s_valid), .s_ready(rdy_p),
        .dout(dout_p), .frame_start(fs_p), .underflow(uf_p), .sof_err(se_p)
    );

    fpdlink_tx_framer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .en(en), .clr_err(clr_err),
        .s_pixel(s_pixel), .s_sof(s_sof), .s_valid(s_valid), .s_ready(rdy_n),
        .dout(dout_n), .frame_start(fs_n), .underflow(uf_n), .sof_err(se_n)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference word builder, straight from the lane-group bit map
    function automatic logic [20:0] mk_grp(input logic [17:0] p, input logic hs,
                                           input logic vs, input logic de);
        logic [20:0] w;
        logic [5:0]  r, g, b;
        r = p[17:12];
        g = p[11:6];
        b = p[5:0];
        w        = '0;
        w[19:14] = r;
        w[11:7]  = g[5:1];
        w[20]    = g[0];
        w[3:0]   = b[5:2];
        w[13:12] = b[1:0];
        w[4]     = hs;
        w[5]     = vs;
        w[6]     = de;
        return w;
    endfunction

    function automatic logic [41:0] mk_word(input logic [35:0] pix, input logic hs,
                                            input logic vs, input logic de);
        return {mk_grp(pix[35:18], hs, vs, de), mk_grp(pix[17:0], hs, vs, de)};
    endfunction

    // Model state: position within the frame as a single index
    int          m_pos;
    logic [41:0] m_dout_p, m_dout_n;
    logic        m_fs, m_uf, m_se;
    logic [41:0] idle_p, idle_n;

    // Next-cycle stimulus
    logic        nx_rst, nx_en, nx_clr, nx_valid, nx_sof, auto_sof;
    logic [35:0] nx_pixel;

    // Frame statistics window
    bit          win_en = 1'b0;
    int          cyc = 0, fs_seen = 0, fs_cyc = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0;

    localparam logic [20:0] RGB_MASK = 21'h1FFF8F;

    task automatic cycle();
        int          h, v;
        logic        de, hsa, vsa, xfer, exp_rdy, uf_set, se_set;
        logic [35:0] pix;
        @(negedge clk);
        cyc++;
        chk("dout_p", 64'(dout_p), 64'(m_dout_p));
        chk("dout_n", 64'(dout_n), 64'(m_dout_n));
        chk("frame_start_p", 64'(fs_p), 64'(m_fs));
        chk("frame_start_n", 64'(fs_n), 64'(m_fs));
        chk("underflow_p", 64'(uf_p), 64'(m_uf));
        chk("underflow_n", 64'(uf_n), 64'(m_uf));
        chk("sof_err_p", 64'(se_p), 64'(m_se));
        chk("sof_err_n", 64'(se_n), 64'(m_se));

        if (win_en && fs_p) begin
            if (fs_seen > 0) begin
                chk("fs_period", 64'(cyc - fs_cyc), 64'(FRAME));
                chk("de_words", 64'(de_cnt), 64'(HA * VA));
                chk("hs_words", 64'(hs_cnt), 64'(HSW * VT));
                chk("vs_words", 64'(vs_cnt), 64'(VSW * HT));
            end
            fs_seen++;
            fs_cyc = cyc;
            de_cnt = 0;
            hs_cnt = 0;
            vs_cnt = 0;
        end
        if (win_en) begin
            de_cnt += int'(dout_p[6]);
            hs_cnt += int'(dout_p[4]);
            vs_cnt += int'(dout_p[5]);
        end

        rst     = nx_rst;
        en      = nx_en;
        clr_err = nx_clr;
        s_valid = nx_valid;
        s_pixel = nx_pixel;
        s_sof   = auto_sof ? (m_pos == 0) : nx_sof;
        #1;

        h   = m_pos % HT;
        v   = m_pos / HT;
        de  = (h < HA) && (v < VA);
        hsa = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vsa = (v >= VA + VFP) && (v < VA + VFP + VSW);
        exp_rdy = en && !rst && de;
        chk("s_ready_p", 64'(rdy_p), 64'(exp_rdy));
        chk("s_ready_n", 64'(rdy_n), 64'(exp_rdy));

        uf_set = 1'b0;
        se_set = 1'b0;
        if (rst) begin
            m_dout_p = idle_p;
            m_dout_n = idle_n;
            m_fs = 1'b0;
            m_uf = 1'b0;
            m_se = 1'b0;
            m_pos = 0;
        end else begin
            if (!en) begin
                m_dout_p = idle_p;
                m_dout_n = idle_n;
                m_fs = 1'b0;
                m_pos = 0;
            end else begin
                xfer = de && s_valid;
                pix  = xfer ? s_pixel : 36'd0;
                m_dout_p = mk_word(pix, hsa, vsa, de);
                m_dout_n = mk_word(pix, !hsa, !vsa, de);
                m_fs   = (m_pos == 0);
                uf_set = de && !s_valid;
                se_set = xfer && (s_sof != (m_pos == 0));
                m_pos  = (m_pos + 1) % FRAME;
            end
            m_uf = (m_uf && !clr_err) || uf_set;
            m_se = (m_se && !clr_err) || se_set;
        end
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (m_pos != target && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
        if (m_pos != target) chk("run_to_timeout", 64'(m_pos), 64'(target));
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_p = mk_word(36'd0, 1'b0, 1'b0, 1'b0);
        idle_n = mk_word(36'd0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1; en = 1'b0; clr_err = 1'b0; s_sof = 1'b0; s_valid = 1'b0; s_pixel = '0;
        m_pos = 0; m_dout_p = idle_p; m_dout_n = idle_n; m_fs = 1'b0; m_uf = 1'b0; m_se = 1'b0;
        nx_rst = 1'b1; nx_en = 1'b1; nx_clr = 1'b0; nx_valid = 1'b1; nx_sof = 1'b0;
        auto_sof = 1'b1; nx_pixel = 36'h1_2345_6789;
        @(posedge clk);
        cycle();
        cycle();

        // Free-running frames with a continuous source
        nx_rst = 1'b0;
        win_en = 1'b1;
        repeat (2 * FRAME + 3) cycle();
        win_en = 1'b0;
        chk("fs_seen", 64'(fs_seen >= 2), 64'd1);

        // Packing of a known pixel at h=3, v=1
        run_to(HT + 3);
        nx_pixel = {6'h3F, 6'h01, 6'h02, 18'd0};
        cycle();
        after_edge();
        chk("pack_r_odd", 64'(dout_p[40:35]), 64'h3F);
        chk("pack_g0_odd", 64'(dout_p[41]), 64'd1);
        chk("pack_b_lo_odd", 64'(dout_p[34:33]), 64'd2);
        chk("pack_even_rgb", 64'(dout_p[20:0] & RGB_MASK), 64'd0);
        chk("pack_de", 64'(dout_p[6]), 64'd1);
        nx_pixel = 36'h9_8765_4321;

        // Single missing pixel at h=6, v=1
        run_to(HT + 6);
        nx_valid = 1'b0;
        cycle();
        nx_valid = 1'b1;
        after_edge();
        chk("uf_word_rgb", 64'(dout_p[20:0] & RGB_MASK), 64'd0);
        chk("uf_word_de", 64'(dout_p[27]), 64'd1);
        chk("uf_set", 64'(uf_p), 64'd1);
        repeat (20) cycle();
        chk("uf_sticky", 64'(uf_p), 64'd1);
        nx_clr = 1'b1;
        cycle();
        nx_clr = 1'b0;
        after_edge();
        chk("uf_cleared", 64'(uf_p), 64'd0);

        // Misplaced start-of-frame at h=3, v=0
        run_to(3);
        auto_sof = 1'b0;
        nx_sof = 1'b1;
        cycle();
        auto_sof = 1'b1;
        nx_sof = 1'b0;
        after_edge();
        chk("sof_err_set", 64'(se_p), 64'd1);
        chk("sof_pixel_kept", 64'(dout_p[40:35]), 64'(nx_pixel[35:30]));
        nx_clr = 1'b1;
        cycle();
        nx_clr = 1'b0;
        run_to(0);
        run_to(5);
        chk("sof_ok_at_origin", 64'(se_p), 64'd0);

        // Abort mid-line at h=4, v=2, then restart
        run_to(2 * HT + 4);
        nx_en = 1'b0;
        cycle();
        after_edge();
        chk("abort_idle", 64'(dout_p), 64'(idle_p));
        chk("abort_ready", 64'(rdy_p), 64'd0);
        repeat (3) cycle();
        nx_en = 1'b1;
        cycle();
        after_edge();
        chk("restart_fs", 64'(fs_p), 64'd1);
        chk("restart_de", 64'(dout_p[6]), 64'd1);

        // Underflow just before a mid-frame reset
        run_to(3 * HT + 1);
        nx_valid = 1'b0;
        cycle();
        nx_valid = 1'b1;
        nx_rst = 1'b1;
        cycle();
        nx_rst = 1'b0;
        after_edge();
        chk("rst_idle_n", 64'(dout_n), 64'h600_0030);
        chk("rst_idle_p", 64'(dout_p), 64'd0);
        chk("rst_uf_clear", 64'(uf_n), 64'd0);
        chk("rst_fs", 64'(fs_n), 64'd0);

        // Random traffic
        repeat (1500) begin
            nx_valid = ($urandom_range(0, 15) != 0);
            nx_pixel = {4'($urandom()), 32'($urandom())};
            nx_en    = ($urandom_range(0, 49) != 0);
            nx_rst   = ($urandom_range(0, 199) == 0);
            nx_clr   = ($urandom_range(0, 19) == 0);
            auto_sof = ($urandom_range(0, 9) != 0);
            nx_sof   = 1'($urandom_range(0, 1));
            cycle();
        end
        nx_rst = 1'b0;
        nx_en = 1'b1;
        auto_sof = 1'b1;
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
